dcache_controller: RTL

Control stage placed directly upstream of the 2-way, 16-set data-cache SRAM, which holds 256-bit lines and 25-bit tag words (valid, dirty, 23-bit tag). It accepts 32-bit word load/store requests from the CPU MEM stage and drives the SRAM's index, tag, data and enable/write lines. On a miss it runs a write-back / refill sequence against data memory and stalls the CPU until the line is resident. Write policy is write-back, write-allocate. Replacement way selection (LRU) belongs to the SRAM.

---
 rtl/dcache_controller_pkg.sv | 24 ++
 rtl/dcache_controller.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/dcache_controller_pkg.sv
// Shared field positions, widths and FSM encoding for the data-cache control stage.
package dcache_controller_pkg;
  localparam int TAG_MSB    = 31;
  localparam int TAG_LSB    = 9;
  localparam int IDX_MSB    = 8;
  localparam int IDX_LSB    = 5;
  localparam int WORD_MSB   = 4;
  localparam int WORD_LSB   = 2;
  localparam int TAG_W      = 23;
  localparam int IDX_W      = 4;
  localparam int TAGWORD_W  = 25;
  localparam int VALID_BIT  = 24;
  localparam int DIRTY_BIT  = 23;
  localparam int LINE_W     = 256;
  localparam int WORD_W     = 32;

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_MISS       = 3'd1,
    S_WRITEBACK  = 3'd2,
    S_READMISS   = 3'd3,
    S_READMISSOK = 3'd4
  } state_e;
endpackage

// File: rtl/dcache_controller.sv
// Write-back / write-allocate control in front of the 2-way data-cache SRAM;
// stalls the CPU while a victim write-back and line refill run against memory.
module dcache_controller
  import dcache_controller_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [31:0]          cpu_addr_i,
  input  logic [WORD_W-1:0]    cpu_data_i,
  input  logic                 cpu_MemRead_i,
  input  logic                 cpu_MemWrite_i,
  output logic [WORD_W-1:0]    cpu_data_o,
  output logic                 cpu_stall_o,
  input  logic [LINE_W-1:0]    mem_data_i,
  input  logic                 mem_ack_i,
  output logic [31:0]          mem_addr_o,
  output logic [LINE_W-1:0]    mem_data_o,
  output logic                 mem_enable_o,
  output logic                 mem_write_o,
  output logic [IDX_W-1:0]     sram_index_o,
  output logic [TAGWORD_W-1:0] sram_tag_o,
  output logic [LINE_W-1:0]    sram_data_o,
  output logic                 sram_enable_o,
  output logic                 sram_write_o,
  input  logic [TAGWORD_W-1:0] sram_tag_i,
  input  logic [LINE_W-1:0]    sram_data_i,
  input  logic                 sram_hit_i
);

  function automatic logic [WORD_W-1:0] word_sel(input logic [LINE_W-1:0] line,
                                                 input logic [2:0] w);
    return line[int'(w)*WORD_W +: WORD_W];
  endfunction

  function automatic logic [LINE_W-1:0] word_merge(input logic [LINE_W-1:0] line,
                                                   input logic [2:0] w,
                                                   input logic [WORD_W-1:0] d);
    logic [LINE_W-1:0] l;
    l = line;
    l[int'(w)*WORD_W +: WORD_W] = d;
    return l;
  endfunction

  logic               req;
  logic [TAG_W-1:0]   tag;
  logic [IDX_W-1:0]   idx;
  logic [2:0]         wsel;
  logic               unused_byte_off;

  state_e             state_q, state_d;
  logic               mem_enable_q, mem_enable_d;
  logic               mem_write_q, mem_write_d;
  logic [31:0]        mem_addr_q, mem_addr_d;
  logic [LINE_W-1:0]  mem_data_q, mem_data_d;

  assign req             = cpu_MemRead_i | cpu_MemWrite_i;
  assign tag             = cpu_addr_i[TAG_MSB:TAG_LSB];
  assign idx             = cpu_addr_i[IDX_MSB:IDX_LSB];
  assign wsel            = cpu_addr_i[WORD_MSB:WORD_LSB];
  assign unused_byte_off = ^cpu_addr_i[1:0];

  assign sram_index_o  = idx;
  assign sram_enable_o = req;
  assign cpu_stall_o   = req & ~((state_q == S_IDLE) & sram_hit_i);
  assign cpu_data_o    = word_sel(sram_data_i, wsel);

  assign mem_enable_o  = mem_enable_q;
  assign mem_write_o   = mem_write_q;
  assign mem_addr_o    = mem_addr_q;
  assign mem_data_o    = mem_data_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      mem_enable_q <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_addr_q   <= '0;
      mem_data_q   <= '0;
    end else begin
      state_q      <= state_d;
      mem_enable_q <= mem_enable_d;
      mem_write_q  <= mem_write_d;
      mem_addr_q   <= mem_addr_d;
      mem_data_q   <= mem_data_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    mem_enable_d = mem_enable_q;
    mem_write_d  = mem_write_q;
    mem_addr_d   = mem_addr_q;
    mem_data_d   = mem_data_q;
    sram_write_o = 1'b0;
    sram_tag_o   = {1'b1, 1'b1, tag};
    sram_data_o  = word_merge(sram_data_i, wsel, cpu_data_i);

    unique case (state_q)
      S_IDLE: begin
        if (req && sram_hit_i) begin
          sram_write_o = cpu_MemWrite_i;
        end else if (req) begin
          state_d = S_MISS;
        end
      end
      S_MISS: begin
        // sram_tag_i/sram_data_i now describe the LRU victim of this set
        if (sram_tag_i[VALID_BIT] && sram_tag_i[DIRTY_BIT]) begin
          mem_enable_d = 1'b1;
          mem_write_d  = 1'b1;
          mem_addr_d   = {sram_tag_i[TAG_W-1:0], idx, 5'b0};
          mem_data_d   = sram_data_i;
          state_d      = S_WRITEBACK;
        end else begin
          mem_enable_d = 1'b1;
          mem_write_d  = 1'b0;
          mem_addr_d   = {tag, idx, 5'b0};
          state_d      = S_READMISS;
        end
      end
      S_WRITEBACK: begin
        if (mem_ack_i) begin
          mem_enable_d = 1'b1;
          mem_write_d  = 1'b0;
          mem_addr_d   = {tag, idx, 5'b0};
          state_d      = S_READMISS;
        end
      end
      S_READMISS: begin
        if (mem_ack_i) begin
          sram_write_o = 1'b1;
          sram_tag_o   = {1'b1, 1'b0, tag};
          sram_data_o  = mem_data_i;
          mem_enable_d = 1'b0;
          state_d      = S_READMISSOK;
        end
      end
      S_READMISSOK: state_d = S_IDLE;
      default:      state_d = S_IDLE;
    endcase
  end

endmodule
